// File: rtl/mmix_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package : mmix_defs
// Purpose : Shared definitions for the memory responder.
//           - Load/store size codes carried on mem_datasize.
//           - State encoding of the responder FSM.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mmix_defs;

   // Request size codes (mem_datasize)
   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_WYDE  = 2'd1;
   localparam logic [1:0] SZ_TETRA = 2'd2;
   localparam logic [1:0] SZ_OCTA  = 2'd3;

   // Responder FSM states
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_HI = 3'd1,
      S_RD_LO = 3'd2,
      S_WR_HI = 3'd3,
      S_WR_LO = 3'd4,
      S_DONE  = 3'd5
   } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_steer.sv
`default_nettype none
// ============================================================================
// Module  : mem_lane_steer
// Purpose : Combinational big-endian lane steering for one 32-bit beat.
//           MMIX byte offset k inside a tetra sits on lane 3-k.
// Ports   : size  - request size code
//           a_lo  - request address bits [1:0]
//           hi    - octa only: 1 selects the upper tetra of wd
//           wd    - right-justified store data
//           rd    - Avalon read data of the beat
//           wdata - replicated/selected write data for the beat
//           be    - byte enables for the beat
//           rdata - right-justified, zero-extended extracted read data
// Rev     : 1.0  initial release
// ============================================================================
module mem_lane_steer
   import mmix_defs::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  a_lo,
   input  logic        hi,
   input  logic [63:0] wd,
   input  logic [31:0] rd,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] rdata
);

   logic [7:0] rd_byte;

   // Offset 0 is the most significant lane
   always_comb begin
      rd_byte = rd[31:24];
      case (a_lo)
         2'd0:    rd_byte = rd[31:24];
         2'd1:    rd_byte = rd[23:16];
         2'd2:    rd_byte = rd[15:8];
         default: rd_byte = rd[7:0];
      endcase
   end

   always_comb begin
      wdata = wd[31:0];
      be    = 4'b1111;
      rdata = rd;
      case (size)
         SZ_BYTE: begin
            wdata = {4{wd[7:0]}};
            be    = 4'b1000 >> a_lo;
            rdata = {24'd0, rd_byte};
         end
         SZ_WYDE: begin
            wdata = {2{wd[15:0]}};
            be    = a_lo[1] ? 4'b0011 : 4'b1100;
            rdata = {16'd0, (a_lo[1] ? rd[15:0] : rd[31:16])};
         end
         SZ_TETRA: begin
            wdata = wd[31:0];
            be    = 4'b1111;
            rdata = rd;
         end
         default: begin
            wdata = hi ? wd[63:32] : wd[31:0];
            be    = 4'b1111;
            rdata = rd;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mmix_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mmix_mem_responder
// Purpose : Executes one MMIX byte/wyde/tetra/octa load or store as one or
//           two 32-bit Avalon-MM beats, returning zero-extended read data
//           and a one-cycle mem_done.
// Ports   : clk, reset_n          - clock, async active-low reset
//           mem_address/datasize  - request address and size
//           mem_read/mem_write    - request levels, held until mem_done
//           mem_writedata         - right-justified store data
//           mem_readdata          - right-justified, zero-extended load data
//           mem_done              - one-cycle completion pulse
//           av_*                  - Avalon-MM master (registered commands)
// Rev     : 1.0  initial release
// ============================================================================
module mmix_mem_responder
   import mmix_defs::*;
#(
   parameter int ADDR_WIDTH = 23
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [63:0]           mem_address,
   input  logic [1:0]            mem_datasize,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [63:0]           mem_writedata,
   output logic [63:0]           mem_readdata,
   output logic                  mem_done,
   output logic [ADDR_WIDTH-1:0] av_address,
   output logic [3:0]            av_byteenable,
   output logic                  av_read,
   output logic                  av_write,
   output logic [31:0]           av_writedata,
   input  logic [31:0]           av_readdata,
   input  logic                  av_readdatavalid,
   input  logic                  av_waitrequest
);

   resp_state_t           state, state_nx;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
   logic [1:0]            size_q, size_nx;
   logic [63:0]           wd_q, wd_nx;
   logic [31:0]           hi_q, hi_nx;
   logic [63:0]           rdata_nx;
   logic [ADDR_WIDTH-1:0] av_address_nx;
   logic [3:0]            av_byteenable_nx;
   logic [31:0]           av_writedata_nx;
   logic                  av_read_nx, av_write_nx;

   logic [1:0]            sel_size;
   logic [1:0]            sel_alo;
   logic [63:0]           sel_wd;
   logic                  steer_hi;
   logic [31:0]           steer_wdata;
   logic [3:0]            steer_be;
   logic [31:0]           steer_rdata;

   // Request address bits above the Avalon window are deliberately dropped
   logic unused_addr_hi;
   assign unused_addr_hi = ^mem_address[63:ADDR_WIDTH];

   // Beat address: tetra-aligned; octa picks the upper (+0) or lower (+4) tetra
   function automatic logic [ADDR_WIDTH-1:0] beat_addr(
      input logic [ADDR_WIDTH-1:0] a,
      input logic [1:0]            sz,
      input logic                  hi
   );
      logic [ADDR_WIDTH-1:0] b;
      b = {a[ADDR_WIDTH-1:2], 2'b00};
      if (sz == SZ_OCTA) b[2] = ~hi;
      return b;
   endfunction

   // Steering is fed the live request while idle (first beat is loaded from
   // it) and the latched request otherwise. The only beat loaded outside
   // S_IDLE is the octa LO beat, hence hi == idle.
   assign sel_size = (state == S_IDLE) ? mem_datasize     : size_q;
   assign sel_alo  = (state == S_IDLE) ? mem_address[1:0] : addr_q[1:0];
   assign sel_wd   = (state == S_IDLE) ? mem_writedata    : wd_q;
   assign steer_hi = (state == S_IDLE);

   mem_lane_steer u_steer (
      .size  (sel_size),
      .a_lo  (sel_alo),
      .hi    (steer_hi),
      .wd    (sel_wd),
      .rd    (av_readdata),
      .wdata (steer_wdata),
      .be    (steer_be),
      .rdata (steer_rdata)
   );

   assign mem_done = (state == S_DONE);

   always_comb begin
      state_nx         = state;
      addr_nx          = addr_q;
      size_nx          = size_q;
      wd_nx            = wd_q;
      hi_nx            = hi_q;
      rdata_nx         = mem_readdata;
      av_address_nx    = av_address;
      av_byteenable_nx = av_byteenable;
      av_writedata_nx  = av_writedata;
      av_read_nx       = av_read;
      av_write_nx      = av_write;

      case (state)
         S_IDLE: begin
            if (mem_read || mem_write) begin
               addr_nx          = mem_address[ADDR_WIDTH-1:0];
               size_nx          = mem_datasize;
               wd_nx            = mem_writedata;
               av_address_nx    = beat_addr(mem_address[ADDR_WIDTH-1:0], mem_datasize, 1'b1);
               av_byteenable_nx = steer_be;
               if (mem_read) begin
                  av_read_nx = 1'b1;
                  state_nx   = (mem_datasize == SZ_OCTA) ? S_RD_HI : S_RD_LO;
               end else begin
                  av_write_nx     = 1'b1;
                  av_writedata_nx = steer_wdata;
                  state_nx        = (mem_datasize == SZ_OCTA) ? S_WR_HI : S_WR_LO;
               end
            end
         end

         // av_read high: command phase; av_read low: awaiting the data beat
         S_RD_HI: begin
            if (av_read) begin
               if (!av_waitrequest) av_read_nx = 1'b0;
            end else if (av_readdatavalid) begin
               hi_nx         = av_readdata;
               av_read_nx    = 1'b1;
               av_address_nx = beat_addr(addr_q, size_q, 1'b0);
               state_nx      = S_RD_LO;
            end
         end

         S_RD_LO: begin
            if (av_read) begin
               if (!av_waitrequest) av_read_nx = 1'b0;
            end else if (av_readdatavalid) begin
               rdata_nx = (size_q == SZ_OCTA) ? {hi_q, av_readdata}
                                              : {32'd0, steer_rdata};
               state_nx = S_DONE;
            end
         end

         S_WR_HI: begin
            if (!av_waitrequest) begin
               av_address_nx   = beat_addr(addr_q, size_q, 1'b0);
               av_writedata_nx = steer_wdata;
               state_nx        = S_WR_LO;
            end
         end

         S_WR_LO: begin
            if (!av_waitrequest) begin
               av_write_nx = 1'b0;
               state_nx    = S_DONE;
            end
         end

         // Requests are not sampled here so the initiator can re-arbitrate
         S_DONE:  state_nx = S_IDLE;

         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         addr_q        <= '0;
         size_q        <= '0;
         wd_q          <= '0;
         hi_q          <= '0;
         mem_readdata  <= '0;
         av_address    <= '0;
         av_byteenable <= '0;
         av_writedata  <= '0;
         av_read       <= 1'b0;
         av_write      <= 1'b0;
      end else begin
         state         <= state_nx;
         addr_q        <= addr_nx;
         size_q        <= size_nx;
         wd_q          <= wd_nx;
         hi_q          <= hi_nx;
         mem_readdata  <= rdata_nx;
         av_address    <= av_address_nx;
         av_byteenable <= av_byteenable_nx;
         av_writedata  <= av_writedata_nx;
         av_read       <= av_read_nx;
         av_write      <= av_write_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mmix_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmix_mem_responder
// Purpose : Self-checking bench for mmix_mem_responder. An Avalon slave
//           model backed by a byte memory answers the DUT; a separate
//           byte-level reference memory predicts load results, and beat
//           counts/latencies are predicted from the slave's chosen stalls.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mmix_mem_responder;

   localparam int AW = 23;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [63:0]   mem_address;
   logic [1:0]    mem_datasize;
   logic          mem_read;
   logic          mem_write;
   logic [63:0]   mem_writedata;
   logic [63:0]   mem_readdata;
   logic          mem_done;
   logic [AW-1:0] av_address;
   logic [3:0]    av_byteenable;
   logic          av_read;
   logic          av_write;
   logic [31:0]   av_writedata;
   logic [31:0]   av_readdata;
   logic          av_readdatavalid;
   logic          av_waitrequest;

   always #5 clk = ~clk;

   mmix_mem_responder #(.ADDR_WIDTH(AW)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .mem_address      (mem_address),
      .mem_datasize     (mem_datasize),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_readdata     (mem_readdata),
      .mem_done         (mem_done),
      .av_address       (av_address),
      .av_byteenable    (av_byteenable),
      .av_read          (av_read),
      .av_write         (av_write),
      .av_writedata     (av_writedata),
      .av_readdata      (av_readdata),
      .av_readdatavalid (av_readdatavalid),
      .av_waitrequest   (av_waitrequest)
   );

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- memories ----------------
   logic [7:0] sl_mem  [int];
   logic [7:0] ref_mem [int];

   function automatic logic [7:0] sm(input int a);
      return sl_mem.exists(a) ? sl_mem[a] : 8'h00;
   endfunction
   function automatic logic [7:0] rm(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   task automatic set_word(input int a, input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         sl_mem[a+k]  = w[31-8*k -: 8];
         ref_mem[a+k] = w[31-8*k -: 8];
      end
   endtask

   // ---------------- Avalon slave model ----------------
   typedef struct {
      bit           wr;
      logic [AW-1:0] addr;
      logic [3:0]   be;
      logic [31:0]  data;
      int           w;
      int           lat;
   } beat_t;

   beat_t beats[$];
   int    wait_q[$];
   int    lat_q[$];
   bit    rand_mode = 1'b0;

   bit            in_cmd   = 1'b0;
   int            wl       = 0;
   int            cur_w    = 0;
   int            pend_cnt = 0;
   logic [31:0]   pend_data;
   logic [AW-1:0] snap_a;
   logic [3:0]    snap_be;
   logic [31:0]   snap_wd;
   logic          snap_wr;

   initial begin
      av_waitrequest   = 1'b0;
      av_readdatavalid = 1'b0;
      av_readdata      = 32'h0;
   end

   always @(negedge clk) begin
      av_readdatavalid = 1'b0;
      av_readdata      = $urandom();
      av_waitrequest   = 1'b0;
      if (!reset_n) in_cmd = 1'b0;
      if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            av_readdatavalid = 1'b1;
            av_readdata      = pend_data;
         end
      end
      if (av_read || av_write) begin
         if (!in_cmd) begin
            in_cmd  = 1'b1;
            if (wait_q.size() > 0) cur_w = wait_q.pop_front();
            else                   cur_w = rand_mode ? int'($urandom_range(0, 2)) : 0;
            wl      = cur_w;
            snap_a  = av_address;
            snap_be = av_byteenable;
            snap_wd = av_writedata;
            snap_wr = av_write;
         end else begin
            chk("stall stable", {av_write, av_byteenable, av_address, (av_write ? av_writedata : 32'h0)},
                                {snap_wr,  snap_be,       snap_a,     (snap_wr  ? snap_wd      : 32'h0)});
         end
         if (wl > 0) begin
            av_waitrequest = 1'b1;
            wl--;
         end else begin
            beat_t b;
            int    base;
            in_cmd = 1'b0;
            base   = int'(av_address);
            chk("beat addr low bits", {62'd0, av_address[1:0]}, 64'd0);
            b.wr   = av_write;
            b.addr = av_address;
            b.be   = av_byteenable;
            b.data = av_writedata;
            b.w    = cur_w;
            b.lat  = 0;
            if (av_write) begin
               for (int l = 0; l < 4; l++)
                  if (av_byteenable[l]) sl_mem[base + 3 - l] = av_writedata[8*l +: 8];
            end else begin
               if (lat_q.size() > 0) b.lat = lat_q.pop_front();
               else                  b.lat = rand_mode ? int'($urandom_range(1, 3)) : 1;
               pend_cnt  = b.lat;
               pend_data = {sm(base), sm(base+1), sm(base+2), sm(base+3)};
            end
            beats.push_back(b);
         end
      end
   end

   // ---------------- one request, checked against the reference ----------------
   logic [63:0] prev_rd = 64'd0;

   task automatic do_op(input bit wr, input logic [1:0] sz, input logic [63:0] addr,
                        input logic [63:0] wd, input string tag);
      int          n;
      int          al;
      int          cyc;
      int          exp_cyc;
      logic [3:0]  be_exp;
      logic [63:0] expv;
      n  = 1 << sz;
      al = int'(addr[AW-1:0]) & ~(n - 1);
      beats.delete();
      mem_address   = addr;
      mem_datasize  = sz;
      mem_writedata = wd;
      mem_read      = !wr;
      mem_write     = wr;
      @(posedge clk);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!mem_done && cyc < 200);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      chk({tag, " done"}, {63'd0, mem_done}, 64'd1);
      exp_cyc = 1;
      foreach (beats[i]) exp_cyc += 1 + beats[i].w + (wr ? 0 : beats[i].lat);
      chk({tag, " done cycle"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, " beat count"}, 64'(beats.size()), (sz == 2'd3) ? 64'd2 : 64'd1);
      be_exp = 4'b0000;
      if (n >= 4) be_exp = 4'b1111;
      else for (int k = al % 4; k < al % 4 + n; k++) be_exp[3-k] = 1'b1;
      foreach (beats[i]) begin
         chk({tag, " beat addr"}, 64'(beats[i].addr), 64'((al & ~3) + 4 * i));
         if (wr) chk({tag, " beat be"}, {60'd0, beats[i].be}, {60'd0, be_exp});
      end
      if (!wr) begin
         expv = 64'd0;
         for (int i = 0; i < n; i++) expv = (expv << 8) | {56'd0, rm(al + i)};
         chk({tag, " readdata"}, mem_readdata, expv);
         prev_rd = expv;
      end else begin
         for (int i = 0; i < n; i++) ref_mem[al + i] = wd[8*(n-1-i) +: 8];
         chk({tag, " readdata held"}, mem_readdata, prev_rd);
      end
      @(negedge clk);
      chk({tag, " done pulse width"}, {63'd0, mem_done}, 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int          cyc;
      bit          saw_done;
      logic [63:0] a;
      int          mism;

      reset_n       = 1'b0;
      mem_address   = 64'd0;
      mem_datasize  = 2'd0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_writedata = 64'd0;

      // Reset with random request inputs: all outputs stay zero
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_address   = {$urandom(), $urandom()};
         mem_datasize  = 2'($urandom_range(0, 3));
         mem_read      = 1'($urandom());
         mem_write     = 1'($urandom());
         mem_writedata = {$urandom(), $urandom()};
         #1;
         chk("reset readdata", mem_readdata, 64'd0);
         chk("reset outputs", {2'd0, mem_done, av_address, av_byteenable, av_read, av_write, av_writedata}, 64'd0);
      end
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reset_n   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("idle no activity", {61'd0, av_read, av_write, mem_done}, 64'd0);
      end

      // STB at 0x1003
      do_op(1'b1, 2'd0, 64'h1003, 64'hAB, "stb");
      chk("stb av_address", 64'(beats[0].addr), 64'h1000);
      chk("stb byteenable", {60'd0, beats[0].be}, 64'b0001);
      chk("stb writedata", {32'd0, beats[0].data}, 64'hABABABAB);

      // LDW at 0x1007
      set_word(32'h1004, 32'h11223344);
      do_op(1'b0, 2'd1, 64'h1007, 64'd0, "ldw");
      chk("ldw value", mem_readdata, 64'h3344);

      // LDO at 0x2005
      set_word(32'h2000, 32'hDEADBEEF);
      set_word(32'h2004, 32'h01234567);
      do_op(1'b0, 2'd3, 64'h2005, 64'd0, "ldo");
      chk("ldo value", mem_readdata, 64'hDEADBEEF01234567);

      // STO at 0x3000 with three stalls on the HI beat
      wait_q.push_back(3);
      do_op(1'b1, 2'd3, 64'h3000, 64'h0102030405060708, "sto");
      chk("sto hi data", {32'd0, beats[0].data}, 64'h01020304);
      chk("sto lo data", {32'd0, beats[1].data}, 64'h05060708);
      do_op(1'b0, 2'd3, 64'h3000, 64'd0, "sto readback");

      // Reset while the LO read is outstanding; its late data must be ignored
      set_word(32'h10, 32'h8000FFFF);
      lat_q.push_back(1);
      lat_q.push_back(5);
      beats.delete();
      mem_address  = 64'h2000;
      mem_datasize = 2'd3;
      mem_read     = 1'b1;
      cyc = 0;
      while (beats.size() < 2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("rst-mid LO issued", 64'(beats.size()), 64'd2);
      reset_n  = 1'b0;
      mem_read = 1'b0;
      #1;
      chk("rst-mid async clear", {62'd0, av_read, mem_done}, 64'd0);
      @(negedge clk);
      reset_n  = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         if (mem_done) saw_done = 1'b1;
      end
      chk("rst-mid no done", {63'd0, saw_done}, 64'd0);
      chk("rst-mid readdata", mem_readdata, 64'd0);
      prev_rd = 64'd0;

      do_op(1'b0, 2'd2, 64'h10, 64'd0, "ldt");
      chk("ldt value", mem_readdata, 64'h000000008000FFFF);

      // Randomized loads/stores with random stalls and read latency
      for (int i = 0; i < 72; i++) begin
         sl_mem[32'h400 + i]  = 8'($urandom());
         ref_mem[32'h400 + i] = sl_mem[32'h400 + i];
      end
      rand_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         a = {$urandom(), $urandom()};
         a[AW-1:0] = AW'(32'h400 + $urandom_range(0, 63));
         do_op(1'($urandom()), 2'($urandom_range(0, 3)), a, {$urandom(), $urandom()},
               $sformatf("rand%0d", i));
      end
      mism = 0;
      for (int i = 0; i < 72; i++)
         if (sm(32'h400 + i) !== rm(32'h400 + i)) mism++;
      chk("memory image", 64'(mism), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
